coin_dispense_ctrl: RTL and testbench

Sequencer that pays out a change amount by pulsing the quarter/dime/nickel ejector solenoids one coin at a time. It tracks per-tube coin inventory and flags a shortfall when the change cannot be made exactly. It sits between the vending FSM's change phase (which supplies `start`/`amount`) and the physical coin release outputs. It replaces the purely combinational release decode with timed, inventory-aware pulses.

---
 rtl/coin_dispense_ctrl.sv | 165 ++++++++++++++++
 tb/tb_coin_dispense_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispense_ctrl.sv
// Coin payout sequencer: pays out a change amount by pulsing the quarter,
// dime and nickel ejector solenoids one coin at a time. Coins are chosen
// greedily from the tube inventory. A shortfall is flagged when the change
// cannot be made exactly.
module coin_dispense_ctrl #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       load_inv,
    input  logic [7:0] inv_q,
    input  logic [7:0] inv_d,
    input  logic [7:0] inv_n,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic       relq,
    output logic       reld,
    output logic       reln,
    output logic [7:0] rem,
    output logic [7:0] cnt_q,
    output logic [7:0] cnt_d,
    output logic [7:0] cnt_n
);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    state_t     state;
    state_t     next_state;
    coin_t      coin;
    coin_t      pick;
    coin_t      active_coin;
    logic [7:0] timer;
    logic       busy_next;
    logic       done_next;
    logic       relq_next;
    logic       reld_next;
    logic       reln_next;

    // Greedy coin choice: largest coin that fits the remainder and is in stock
    always_comb begin
        pick = COIN_NONE;
        if (rem >= 8'd25 && cnt_q != 8'd0) begin
            pick = COIN_Q;
        end else if (rem >= 8'd10 && cnt_d != 8'd0) begin
            pick = COIN_D;
        end else if (rem >= 8'd5 && cnt_n != 8'd0) begin
            pick = COIN_N;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; load_inv wins over a simultaneous start
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!load_inv && start) next_state = SELECT;
            SELECT:  next_state = (pick != COIN_NONE) ? PULSE : DONE;
            PULSE:   if (timer == PULSE_LAST) next_state = GAP;
            GAP:     if (timer == GAP_LAST) next_state = SELECT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Cycle counter for pulse and gap widths, cleared on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= 8'd0;
        end else if (next_state != state) begin
            timer <= 8'd0;
        end else if (state == PULSE || state == GAP) begin
            timer <= timer + 8'd1;
        end else begin
            timer <= 8'd0;
        end
    end

    // Inventory, remainder, selected coin and shortfall flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem   <= 8'd0;
            cnt_q <= 8'd0;
            cnt_d <= 8'd0;
            cnt_n <= 8'd0;
            coin  <= COIN_NONE;
            short <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_inv) begin
                        cnt_q <= inv_q;
                        cnt_d <= inv_d;
                        cnt_n <= inv_n;
                    end else if (start) begin
                        rem   <= amount;
                        short <= 1'b0;
                    end
                end
                SELECT: begin
                    coin <= pick;
                    case (pick)
                        COIN_Q: begin
                            rem   <= rem - 8'd25;
                            cnt_q <= cnt_q - 8'd1;
                        end
                        COIN_D: begin
                            rem   <= rem - 8'd10;
                            cnt_d <= cnt_d - 8'd1;
                        end
                        COIN_N: begin
                            rem   <= rem - 8'd5;
                            cnt_n <= cnt_n - 8'd1;
                        end
                        default: short <= (rem != 8'd0);
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        active_coin = (state == SELECT) ? pick : coin;
        busy_next   = (next_state == SELECT) || (next_state == PULSE) || (next_state == GAP);
        done_next   = (next_state == DONE);
        relq_next   = (next_state == PULSE) && (active_coin == COIN_Q);
        reld_next   = (next_state == PULSE) && (active_coin == COIN_D);
        reln_next   = (next_state == PULSE) && (active_coin == COIN_N);
    end

    // Output registers keep solenoid drives glitch-free; reset drops them at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            relq <= 1'b0;
            reld <= 1'b0;
            reln <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            relq <= relq_next;
            reld <= reld_next;
            reln <= reln_next;
        end
    end

endmodule

// File: tb/tb_coin_dispense_ctrl.sv
// Testbench for coin_dispense_ctrl: directed scenarios plus randomized
// payouts, all checked every cycle against a payout-schedule model.
module tb_coin_dispense_ctrl;

    localparam int P   = 4;
    localparam int G   = 2;
    localparam int PER = 1 + P + G;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_inv;
    logic [7:0] amount;
    logic [7:0] inv_q;
    logic [7:0] inv_d;
    logic [7:0] inv_n;
    logic       busy;
    logic       done;
    logic       short;
    logic       relq;
    logic       reld;
    logic       reln;
    logic [7:0] rem;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_n;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    coin_dispense_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .load_inv(load_inv), .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n),
        .busy(busy), .done(done), .short(short),
        .relq(relq), .reld(reld), .reln(reln),
        .rem(rem), .cnt_q(cnt_q), .cnt_d(cnt_d), .cnt_n(cnt_n)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Model state: the payout is planned as a list of coin values at acceptance,
    // then outputs follow from the cycle offset since the accepting edge.
    bit m_active;
    int m_t;
    int m_amount;
    int m_sq, m_sd, m_sn;
    int m_coin[$];
    int m_rem, m_q, m_d, m_n;
    bit m_short;
    int p_rem, p_q, p_d, p_n;
    bit p_short;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic void plan_payout();
        int r, q, d, n;
        r = m_amount; q = m_sq; d = m_sd; n = m_sn;
        m_coin.delete();
        while (1) begin
            if (r >= 25 && q > 0) begin m_coin.push_back(25); r -= 25; q--; end
            else if (r >= 10 && d > 0) begin m_coin.push_back(10); r -= 10; d--; end
            else if (r >= 5 && n > 0) begin m_coin.push_back(5); r -= 5; n--; end
            else break;
        end
        p_rem = r; p_q = q; p_d = d; p_n = n; p_short = (r != 0);
    endfunction

    // Model update on each active edge, reset asynchronously like the DUT
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_t = 0; m_rem = 0; m_q = 0; m_d = 0; m_n = 0; m_short = 0;
            m_coin.delete();
        end else if (!m_active) begin
            if (load_inv) begin
                m_q = inv_q; m_d = inv_d; m_n = inv_n;
            end else if (start) begin
                m_amount = amount; m_sq = m_q; m_sd = m_d; m_sn = m_n;
                plan_payout();
                m_active = 1; m_t = 1; m_short = 0; m_rem = amount;
            end
        end else if (m_t == 2 + PER * m_coin.size()) begin
            m_active = 0;
            m_rem = p_rem; m_q = p_q; m_d = p_d; m_n = p_n; m_short = p_short;
        end else begin
            m_t++;
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        int n, m, i, ph, uq, ud, un, used;
        logic eb, ed, es, erq, erd, ern;
        logic [7:0] er, eq, edd, en;
        if (checking) begin
            eb = 0; ed = 0; es = m_short; erq = 0; erd = 0; ern = 0;
            er = 8'(m_rem); eq = 8'(m_q); edd = 8'(m_d); en = 8'(m_n);
            if (m_active) begin
                n  = m_coin.size();
                eb = (m_t <= 1 + PER * n);
                ed = (m_t == 2 + PER * n);
                es = ed ? p_short : 1'b0;
                if (m_t >= 2 && m_t <= 1 + PER * n) begin
                    i  = (m_t - 1) / PER;
                    ph = (m_t - 1) % PER;
                    if (ph >= 1 && ph <= P) begin
                        erq = (m_coin[i] == 25);
                        erd = (m_coin[i] == 10);
                        ern = (m_coin[i] == 5);
                    end
                end
                m = (m_t >= 2) ? ((m_t - 2) / PER + 1) : 0;
                if (m > n) m = n;
                uq = 0; ud = 0; un = 0; used = 0;
                for (int k = 0; k < m; k++) begin
                    used += m_coin[k];
                    if (m_coin[k] == 25) uq++;
                    else if (m_coin[k] == 10) ud++;
                    else un++;
                end
                er = 8'(m_amount - used);
                eq = 8'(m_sq - uq); edd = 8'(m_sd - ud); en = 8'(m_sn - un);
            end
            check_output("busy", {7'd0, busy}, {7'd0, eb});
            check_output("done", {7'd0, done}, {7'd0, ed});
            check_output("short", {7'd0, short}, {7'd0, es});
            check_output("relq", {7'd0, relq}, {7'd0, erq});
            check_output("reld", {7'd0, reld}, {7'd0, erd});
            check_output("reln", {7'd0, reln}, {7'd0, ern});
            check_output("rem", rem, er);
            check_output("cnt_q", cnt_q, eq);
            check_output("cnt_d", cnt_d, edd);
            check_output("cnt_n", cnt_n, en);
        end
    end

    // Drive one cycle of start/load_inv, returning just after the sampling edge
    task automatic apply_stimulus(input bit ld, input bit st, input logic [7:0] amt,
                                  input logic [7:0] q, input logic [7:0] d, input logic [7:0] n);
        load_inv = ld; start = st; amount = amt; inv_q = q; inv_d = d; inv_n = n;
        @(posedge clk); #1;
        load_inv = 0; start = 0;
    endtask

    // Wait for done with a cycle budget, then step into IDLE
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_output("done_seen", {7'd0, done}, 8'd1);
        @(posedge clk); #1;
    endtask

    int lat;
    int waited;

    initial begin
        reset = 0; start = 0; load_inv = 0; amount = 0; inv_q = 0; inv_d = 0; inv_n = 0;
        @(negedge clk); checking = 1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", {7'd0, busy}, 8'd0);
        check_output("reset_rem", rem, 8'd0);
        reset = 1;
        @(posedge clk); #1;

        // Basic payout: one of each coin
        apply_stimulus(1, 0, 0, 2, 2, 2);
        apply_stimulus(0, 1, 40, 0, 0, 0);
        wait_done(300, lat);
        check_output("t1_latency", 8'(lat), 8'd22);
        check_output("t1_rem", rem, 8'd0);
        check_output("t1_cnt_q", cnt_q, 8'd1);
        check_output("t1_cnt_d", cnt_d, 8'd1);
        check_output("t1_cnt_n", cnt_n, 8'd1);
        check_output("t1_short", {7'd0, short}, 8'd0);

        // No quarters: one dime then five nickels
        apply_stimulus(1, 0, 0, 0, 1, 5);
        apply_stimulus(0, 1, 35, 0, 0, 0);
        wait_done(300, lat);
        check_output("t2_latency", 8'(lat), 8'd43);
        check_output("t2_cnt_n", cnt_n, 8'd0);
        check_output("t2_short", {7'd0, short}, 8'd0);

        // Empty tubes leave a shortfall
        apply_stimulus(1, 0, 0, 1, 0, 0);
        apply_stimulus(0, 1, 30, 0, 0, 0);
        wait_done(300, lat);
        check_output("t3_rem", rem, 8'd5);
        check_output("t3_short", {7'd0, short}, 8'd1);

        // Amount not a multiple of five
        apply_stimulus(1, 0, 0, 9, 9, 9);
        apply_stimulus(0, 1, 7, 0, 0, 0);
        wait_done(300, lat);
        check_output("t4_latency", 8'(lat), 8'd8);
        check_output("t4_rem", rem, 8'd2);
        check_output("t4_short", {7'd0, short}, 8'd1);

        // Zero amount: done right after the empty select
        apply_stimulus(0, 1, 0, 0, 0, 0);
        wait_done(300, lat);
        check_output("t5_latency", 8'(lat), 8'd1);
        check_output("t5_short", {7'd0, short}, 8'd0);

        // start while busy is ignored
        apply_stimulus(1, 0, 0, 3, 3, 3);
        apply_stimulus(0, 1, 25, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus(0, 1, 50, 0, 0, 0);
        wait_done(300, lat);
        check_output("t6_cnt_q", cnt_q, 8'd2);
        check_output("t6_busy", {7'd0, busy}, 8'd0);

        // start together with load_inv: load only
        apply_stimulus(1, 1, 50, 4, 4, 4);
        check_output("t7_busy", {7'd0, busy}, 8'd0);
        check_output("t7_cnt_q", cnt_q, 8'd4);

        // Reset in the middle of a quarter pulse
        apply_stimulus(0, 1, 25, 0, 0, 0);
        waited = 0;
        while (relq !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output("t8_relq_on", {7'd0, relq}, 8'd1);
        reset = 0;
        #1;
        check_output("t8_relq_off", {7'd0, relq}, 8'd0);
        check_output("t8_busy", {7'd0, busy}, 8'd0);
        check_output("t8_cnt_q", cnt_q, 8'd0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;

        // Randomized payouts with occasional reloads and ignored requests
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0 || it == 0)
                apply_stimulus(1, 0, 0, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                               8'($urandom_range(0, 6)));
            apply_stimulus(0, 1, 8'($urandom_range(0, 130)), 0, 0, 0);
            if ($urandom_range(0, 1) == 1)
                apply_stimulus(1'($urandom_range(0, 1)), 1, 8'($urandom_range(0, 255)), 9, 9, 9);
            wait_done(400, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
